// File: rtl/mvu_seq.sv
// Self-sequencing bit-serial matrix-vector unit: n lanes of n-wide binary dot
// products, walking all weight/input bit-plane pairs from one start pulse.

module mvu_lane #(
  parameter int n = 64,
  parameter int w = 32
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         first_i,
  input  logic         news_i,
  input  logic         neg_i,
  input  logic [n-1:0] wrow_i,
  input  logic [n-1:0] x_i,
  output logic [w-1:0] acc_o
);
  localparam int CW = $clog2(n) + 1;

  logic [CW-1:0] cnt;
  logic [w-1:0]  p, base, acc_q, acc_d;

  always_comb begin
    cnt = '0;
    for (int j = 0; j < n; j++) cnt = cnt + CW'(wrow_i[j] & x_i[j]);
    p     = neg_i ? -w'(cnt) : w'(cnt);
    // A new significance level shifts the running sum up one bit.
    base  = first_i ? '0 : (news_i ? {acc_q[w-2:0], 1'b0} : acc_q);
    acc_d = base + p;
  end

  always_ff @(posedge clk_i) begin
    if (clr_i)     acc_q <= '0;
    else if (en_i) acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

module mvu_seq #(
  parameter int n      = 64,
  parameter int w      = 32,
  parameter int WDEPTH = 64,
  parameter int IDEPTH = 64,
  parameter int MAXP   = 8
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      wwen,
  input  logic [$clog2(WDEPTH)-1:0] waddr,
  input  logic [$clog2(n)-1:0]      wrow,
  input  logic [n-1:0]              wdata,
  input  logic                      iwen,
  input  logic [$clog2(IDEPTH)-1:0] iaddr,
  input  logic [n-1:0]              idata,
  input  logic                      start,
  input  logic [$clog2(WDEPTH)-1:0] wbase,
  input  logic [$clog2(IDEPTH)-1:0] ibase,
  input  logic [$clog2(MAXP)-1:0]   wprec,
  input  logic [$clog2(MAXP)-1:0]   iprec,
  input  logic                      wsigned,
  input  logic                      isigned,
  output logic                      busy,
  output logic                      ovalid,
  input  logic                      oready,
  output logic [n*w-1:0]            O
);
  localparam int WAW = $clog2(WDEPTH);
  localparam int IAW = $clog2(IDEPTH);
  localparam int PW  = $clog2(MAXP);
  localparam int SW  = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [n*n-1:0] wmem [WDEPTH];
  logic [n-1:0]   imem [IDEPTH];

  logic [1:0]     state_q, state_d;
  logic [WAW-1:0] wbase_q;
  logic [IAW-1:0] ibase_q;
  logic [PW-1:0]  wp_q, ip_q;
  logic           ws_q, is_q;
  logic [SW-1:0]  s_q, s_d, bw_q, bw_d;
  logic           first_q, first_d, news_q, news_d;

  logic           vld_q, fst_q, nws_q, neg_q;
  logic [n*n-1:0] rdw_q;
  logic [n-1:0]   rdx_q;
  logic           ovalid_q;
  logic [n*w-1:0] o_q;
  logic [n-1:0][w-1:0] acc_w;

  logic [SW-1:0]  bx, lo, s_m1, wp_ext, ip_ext;
  logic           neg_d;
  logic [WAW:0]   wsum;
  logic [IAW:0]   isum;
  logic [WAW-1:0] wra;
  logic [IAW-1:0] ira;

  always_comb begin
    wp_ext = SW'(wp_q);
    ip_ext = SW'(ip_q);
    bx     = s_q - bw_q;
    lo     = (s_q > ip_ext) ? s_q - ip_ext : '0;
    s_m1   = s_q - SW'(1);
    neg_d  = (ws_q && bw_q == wp_ext) ^ (is_q && bx == ip_ext);
    // Bit-plane addresses wrap around the end of each memory.
    wsum   = {1'b0, wbase_q} + (WAW+1)'(bw_q);
    isum   = {1'b0, ibase_q} + (IAW+1)'(bx);
    wra    = (wsum >= (WAW+1)'(WDEPTH)) ? WAW'(wsum - (WAW+1)'(WDEPTH)) : WAW'(wsum);
    ira    = (isum >= (IAW+1)'(IDEPTH)) ? IAW'(isum - (IAW+1)'(IDEPTH)) : IAW'(isum);
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    bw_d    = bw_q;
    first_d = first_q;
    news_d  = news_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        s_d     = SW'(wprec) + SW'(iprec);
        bw_d    = SW'(wprec);
        first_d = 1'b1;
        news_d  = 1'b0;
      end
      S_RUN: begin
        first_d = 1'b0;
        if (bw_q == lo) begin
          if (s_q == '0) state_d = S_DRAIN;
          else begin
            s_d    = s_m1;
            bw_d   = (s_m1 > wp_ext) ? wp_ext : s_m1;
            news_d = 1'b1;
          end
        end else begin
          bw_d   = bw_q - SW'(1);
          news_d = 1'b0;
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: if (ovalid_q && oready) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      wbase_q  <= '0;
      ibase_q  <= '0;
      wp_q     <= '0;
      ip_q     <= '0;
      ws_q     <= 1'b0;
      is_q     <= 1'b0;
      s_q      <= '0;
      bw_q     <= '0;
      first_q  <= 1'b0;
      news_q   <= 1'b0;
      vld_q    <= 1'b0;
      fst_q    <= 1'b0;
      nws_q    <= 1'b0;
      neg_q    <= 1'b0;
      ovalid_q <= 1'b0;
      o_q      <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      bw_q    <= bw_d;
      first_q <= first_d;
      news_q  <= news_d;
      if (state_q == S_IDLE && start) begin
        wbase_q <= wbase;
        ibase_q <= ibase;
        wp_q    <= wprec;
        ip_q    <= iprec;
        ws_q    <= wsigned;
        is_q    <= isigned;
      end
      // Step tags travel alongside the one-cycle memory read.
      vld_q <= (state_q == S_RUN);
      fst_q <= first_q;
      nws_q <= news_q;
      neg_q <= neg_d;
      if (state_q == S_DONE) begin
        if (!ovalid_q) begin
          ovalid_q <= 1'b1;
          o_q      <= acc_w;
        end else if (oready) begin
          ovalid_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wwen && state_q == S_IDLE) wmem[waddr][wrow*n +: n] <= wdata;
    if (iwen && state_q == S_IDLE) imem[iaddr] <= idata;
    rdw_q <= wmem[wra];
    rdx_q <= imem[ira];
  end

  for (genvar i = 0; i < n; i++) begin : g_lane
    mvu_lane #(.n(n), .w(w)) u_lane (
      .clk_i   (clk),
      .clr_i   (clr),
      .en_i    (vld_q),
      .first_i (fst_q),
      .news_i  (nws_q),
      .neg_i   (neg_q),
      .wrow_i  (rdw_q[i*n +: n]),
      .x_i     (rdx_q),
      .acc_o   (acc_w[i])
    );
  end

  assign busy   = (state_q != S_IDLE);
  assign ovalid = ovalid_q;
  assign O      = o_q;
endmodule

// File: tb/tb_mvu_seq.sv
// Randomised scoreboard bench for mvu_seq: expected lane results come from an
// integer matrix-vector product over values rebuilt from the written bit-planes.

module tb_mvu_seq;
  localparam int n = 4, w = 32, WDEPTH = 16, IDEPTH = 16, MAXP = 8;
  localparam int OW = n * w;

  logic clk, clr, wwen, iwen, start, wsigned, isigned, oready;
  logic [3:0] waddr, iaddr, wbase, ibase;
  logic [1:0] wrow;
  logic [n-1:0] wdata, idata;
  logic [2:0] wprec, iprec;
  logic busy, ovalid;
  logic [OW-1:0] O;

  mvu_seq #(.n(n), .w(w), .WDEPTH(WDEPTH), .IDEPTH(IDEPTH), .MAXP(MAXP)) dut (
    .clk(clk), .clr(clr), .wwen(wwen), .waddr(waddr), .wrow(wrow), .wdata(wdata),
    .iwen(iwen), .iaddr(iaddr), .idata(idata), .start(start), .wbase(wbase),
    .ibase(ibase), .wprec(wprec), .iprec(iprec), .wsigned(wsigned), .isigned(isigned),
    .busy(busy), .ovalid(ovalid), .oready(oready), .O(O)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [n-1:0] wm [WDEPTH][n];
  logic [n-1:0] im [IDEPTH];
  logic [OW-1:0] sb[$];
  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Signed/unsigned integer values rebuilt from planes, then a plain dot product.
  function automatic logic [OW-1:0] model(int wb, int ib, int wp, int ip, bit ws, bit xs);
    logic [OW-1:0] r;
    longint acc, wv, xv;
    r = '0;
    for (int i = 0; i < n; i++) begin
      acc = 0;
      for (int j = 0; j < n; j++) begin
        wv = 0;
        xv = 0;
        for (int b = 0; b <= wp; b++) if (wm[(wb+b)%WDEPTH][i][j]) wv += longint'(1) << b;
        for (int b = 0; b <= ip; b++) if (im[(ib+b)%IDEPTH][j]) xv += longint'(1) << b;
        if (ws && wv >= (longint'(1) << wp)) wv -= longint'(1) << (wp+1);
        if (xs && xv >= (longint'(1) << ip)) xv -= longint'(1) << (ip+1);
        acc += wv * xv;
      end
      r[i*w +: w] = acc[w-1:0];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!clr && ovalid && oready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL stray_ovalid: got result %0h expected none", O);
      end else begin
        logic [OW-1:0] e;
        e = sb.pop_front();
        chk("result", O, e);
      end
    end
  end

  task automatic wr_w(input int a, input int r, input logic [n-1:0] d);
    wwen = 1'b1; waddr = 4'(a); wrow = 2'(r); wdata = d;
    tick;
    wwen = 1'b0;
    wm[a][r] = d;
  endtask

  task automatic wr_i(input int a, input logic [n-1:0] d);
    iwen = 1'b1; iaddr = 4'(a); idata = d;
    tick;
    iwen = 1'b0;
    im[a] = d;
  endtask

  task automatic run_job(input int wb, input int ib, input int wp, input int ip,
                         input bit ws, input bit xs, input int hold);
    logic [OW-1:0] e;
    int cnt;
    e = model(wb, ib, wp, ip, ws, xs);
    sb.push_back(e);
    oready = (hold == 0);
    wbase = 4'(wb); ibase = 4'(ib); wprec = 3'(wp); iprec = 3'(ip);
    wsigned = ws; isigned = xs; start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_after_start", 1'(busy), 1);
    cnt = 0;
    while (!ovalid && cnt < 300) begin
      tick;
      cnt++;
    end
    chk("latency", cnt, (wp+1)*(ip+1)+2);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        chk("hold_ovalid", 1'(ovalid), 1);
        chk("hold_busy", 1'(busy), 1);
        chk("hold_O", O, e);
        if (h == 1) begin
          start = 1'b1;
          wwen = 1'b1; waddr = 4'(wb); wrow = 2'd0; wdata = ~wm[wb][0];
        end
        tick;
        start = 1'b0;
        wwen = 1'b0;
      end
      start = 1'b1;
    end
    oready = 1'b1;
    tick;
    start = 1'b0;
    chk("ovalid_after_hs", 1'(ovalid), 0);
    chk("busy_after_hs", 1'(busy), 0);
  endtask

  initial begin
    int wb, ib, wp, ip;
    clr = 1'b1; wwen = 0; iwen = 0; start = 0; oready = 1;
    waddr = 0; wrow = 0; wdata = 0; iaddr = 0; idata = 0;
    wbase = 0; ibase = 0; wprec = 0; iprec = 0; wsigned = 0; isigned = 0;
    tick; tick;
    chk("rst_busy", 1'(busy), 0);
    chk("rst_ovalid", 1'(ovalid), 0);
    chk("rst_O", O, '0);
    clr = 1'b0;

    for (int a = 0; a < WDEPTH; a++) for (int r = 0; r < n; r++) wr_w(a, r, 4'($urandom));
    for (int a = 0; a < IDEPTH; a++) wr_i(a, 4'($urandom));

    // Single-bit job.
    wr_w(0, 0, 4'b1011); wr_i(0, 4'b1101);
    run_job(0, 0, 0, 0, 0, 0, 0);
    chk("t1_lane0", O[0 +: w], 2);

    // Two-bit unsigned: W=3, x=2.
    for (int r = 0; r < n; r++) begin wr_w(2, r, 4'hF); wr_w(3, r, 4'hF); end
    wr_i(2, 4'h0); wr_i(3, 4'hF); wr_i(4, 4'hF); wr_i(5, 4'hF);
    run_job(2, 2, 1, 1, 0, 0, 0);
    for (int i = 0; i < n; i++) chk("t2_lane", O[i*w +: w], 24);

    run_job(2, 4, 1, 1, 1, 0, 0);
    for (int i = 0; i < n; i++) chk("t3_wsigned", O[i*w +: w], 32'hFFFFFFF4);
    run_job(2, 2, 1, 1, 1, 1, 0);
    for (int i = 0; i < n; i++) chk("t3_both_signed", O[i*w +: w], 8);

    // Backpressure with disturbing start/write; the rerun shows memory untouched.
    run_job(2, 2, 1, 1, 0, 0, 5);
    run_job(2, 2, 1, 1, 0, 0, 0);
    chk("t4_rerun_lane0", O[0 +: w], 24);

    // Abort in the middle of a 16-step job.
    oready = 1'b1;
    wbase = 4'd6; ibase = 4'd6; wprec = 3'd3; iprec = 3'd3; wsigned = 1; isigned = 1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("clr_busy", 1'(busy), 0);
    chk("clr_ovalid", 1'(ovalid), 0);
    chk("clr_O", O, '0);
    repeat (30) tick;
    chk("clr_no_ovalid", 1'(ovalid), 0);
    run_job(6, 6, 3, 3, 1, 1, 0);

    // Address wrap and full-precision all-ones.
    run_job(15, 15, 1, 0, 0, 0, 0);
    for (int a = 12; a < 20; a++) begin
      for (int r = 0; r < n; r++) wr_w(a % WDEPTH, r, 4'hF);
      wr_i(a % IDEPTH, 4'hF);
    end
    run_job(12, 12, 7, 7, 0, 0, 0);
    for (int i = 0; i < n; i++) chk("t6_max", O[i*w +: w], 260100);

    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(0, 3)) wr_w($urandom_range(0, WDEPTH-1), $urandom_range(0, n-1), 4'($urandom));
      repeat ($urandom_range(0, 2)) wr_i($urandom_range(0, IDEPTH-1), 4'($urandom));
      wb = $urandom_range(0, WDEPTH-1);
      ib = $urandom_range(0, IDEPTH-1);
      wp = $urandom_range(0, MAXP-1);
      ip = $urandom_range(0, MAXP-1);
      run_job(wb, ib, wp, ip, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    repeat (3) tick;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
